wb_stage: RTL and testbench

Write-back stage of the RV32S pipeline, directly downstream of the memory-access (ME) stage. It accepts one retiring instruction per handshake and writes its result into the integer (R), float (F) or matrix (M) register file. It issues a 512-bit matrix result as four 128-bit beats through a dedicated beat sequencer. It also publishes retirement, the committed PC, the redirect request and a 64-bit retired-instruction counter.

---
 rtl/wb_stage.sv | 110 +++++++++++
 tb/tb_wb_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per handshake into the R, F or M
// register file. Matrix results leave as four 128-bit beats, lowest first.
//
// state | meaning
// IDLE  | nothing pending, a single-beat write, or matrix beat 3 in flight
// MBEAT | matrix beat 0..2 in flight, stage register locked
module wb_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         ME_valid,
  output logic         ready,
  input  logic [1:0]   rd_group,
  input  logic [4:0]   rd_index,
  input  logic         pc_opt,
  input  logic [31:0]  npc,
  input  logic [31:0]  res_R,
  input  logic [31:0]  res_F,
  input  logic [511:0] res_M,
  output logic         R_wen,
  output logic [4:0]   R_waddr,
  output logic [31:0]  R_wdata,
  output logic         F_wen,
  output logic [4:0]   F_waddr,
  output logic [31:0]  F_wdata,
  output logic         M_wen,
  output logic [6:0]   M_waddr,
  output logic [127:0] M_wdata,
  output logic         retire,
  output logic [31:0]  commit_pc,
  output logic         redirect,
  output logic [63:0]  instret
);

  typedef enum logic {IDLE, MBEAT} state_t;

  state_t       state;
  logic [1:0]   beat;
  logic         pend;
  logic [1:0]   s_group;
  logic [4:0]   s_index;
  logic         s_pc_opt;
  logic [31:0]  s_npc;
  logic [31:0]  s_res_r;
  logic [31:0]  s_res_f;
  logic [511:0] s_res_m;

  logic accept;
  logic last;

  // Pending work in IDLE is always the final write of its instruction.
  assign ready  = rst & (state != MBEAT);
  assign accept = ME_valid & ready;
  assign last   = pend & (state == IDLE);

  // Stage register, beat sequencer and retirement bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= 2'd0;
      pend      <= 1'b0;
      s_group   <= 2'd0;
      s_index   <= 5'd0;
      s_pc_opt  <= 1'b0;
      s_npc     <= 32'd0;
      s_res_r   <= 32'd0;
      s_res_f   <= 32'd0;
      s_res_m   <= 512'd0;
      commit_pc <= 32'd0;
      instret   <= 64'd0;
    end else begin
      if (accept) begin
        s_group  <= rd_group;
        s_index  <= rd_index;
        s_pc_opt <= pc_opt;
        s_npc    <= npc;
        s_res_r  <= res_R;
        s_res_f  <= res_F;
        s_res_m  <= res_M;
        pend     <= 1'b1;
        beat     <= 2'd0;
        if (rd_group == 2'b11) state <= MBEAT;
      end else if (last) begin
        pend <= 1'b0;
      end
      // Beat 3 is issued from IDLE so the next accept can overlap it.
      if (state == MBEAT) begin
        beat <= beat + 2'd1;
        if (beat == 2'd2) state <= IDLE;
      end
      if (last) begin
        commit_pc <= s_npc;
        instret   <= instret + 64'd1;
      end
    end
  end

  // Write ports come straight from the stage register; x0 writes are dropped.
  assign R_wen    = pend & (s_group == 2'b01) & (s_index != 5'd0);
  assign R_waddr  = s_index;
  assign R_wdata  = s_res_r;
  assign F_wen    = pend & (s_group == 2'b10);
  assign F_waddr  = s_index;
  assign F_wdata  = s_res_f;
  assign M_wen    = pend & (s_group == 2'b11);
  assign M_waddr  = {s_index, beat};
  assign M_wdata  = s_res_m[{beat, 7'd0} +: 128];
  assign retire   = last;
  assign redirect = last & s_pc_opt;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a queue-of-cycles model of expected write-port activity
// checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         ME_valid;
  logic         ready;
  logic [1:0]   rd_group;
  logic [4:0]   rd_index;
  logic         pc_opt;
  logic [31:0]  npc;
  logic [31:0]  res_R;
  logic [31:0]  res_F;
  logic [511:0] res_M;
  logic         R_wen, F_wen, M_wen;
  logic [4:0]   R_waddr, F_waddr;
  logic [6:0]   M_waddr;
  logic [31:0]  R_wdata, F_wdata;
  logic [127:0] M_wdata;
  logic         retire, redirect;
  logic [31:0]  commit_pc;
  logic [63:0]  instret;

  wb_stage dut (
    .clk(clk), .rst(rst), .ME_valid(ME_valid), .ready(ready),
    .rd_group(rd_group), .rd_index(rd_index), .pc_opt(pc_opt), .npc(npc),
    .res_R(res_R), .res_F(res_F), .res_M(res_M),
    .R_wen(R_wen), .R_waddr(R_waddr), .R_wdata(R_wdata),
    .F_wen(F_wen), .F_waddr(F_waddr), .F_wdata(F_wdata),
    .M_wen(M_wen), .M_waddr(M_waddr), .M_wdata(M_wdata),
    .retire(retire), .commit_pc(commit_pc), .redirect(redirect),
    .instret(instret)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;
  int ret_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One entry per output cycle the stage owes; front entry is the current cycle.
  typedef struct packed {
    logic         r_wen;
    logic [4:0]   r_addr;
    logic [31:0]  r_data;
    logic         f_wen;
    logic [4:0]   f_addr;
    logic [31:0]  f_data;
    logic         m_wen;
    logic [6:0]   m_addr;
    logic [127:0] m_data;
    logic         ret;
    logic         redir;
    logic [31:0]  pc;
  } rec_t;

  rec_t        q[$];
  logic [31:0] m_commit;
  logic [63:0] m_instret;

  function automatic bit m_ready();
    return rst && (q.size() <= 1);
  endfunction

  // Model: drain one owed cycle per clock, enqueue the cycles a new accept owes.
  always @(posedge clk or negedge rst) begin
    rec_t r;
    bit   rdy;
    if (!rst) begin
      q.delete();
      m_commit  = 32'd0;
      m_instret = 64'd0;
    end else begin
      rdy = (q.size() <= 1);
      if (q.size() > 0) begin
        r = q.pop_front();
        if (r.ret) begin
          m_commit  = r.pc;
          m_instret = m_instret + 64'd1;
        end
      end
      if (ME_valid && rdy) begin
        if (rd_group == 2'b11) begin
          for (int b = 0; b < 4; b++) begin
            r = '0;
            r.m_wen  = 1'b1;
            r.m_addr = {rd_index, 2'(b)};
            r.m_data = res_M[b*128 +: 128];
            r.ret    = (b == 3);
            r.redir  = (b == 3) && pc_opt;
            r.pc     = npc;
            q.push_back(r);
          end
        end else begin
          r = '0;
          r.r_wen  = (rd_group == 2'b01) && (rd_index != 5'd0);
          r.r_addr = rd_index;
          r.r_data = res_R;
          r.f_wen  = (rd_group == 2'b10);
          r.f_addr = rd_index;
          r.f_data = res_F;
          r.ret    = 1'b1;
          r.redir  = pc_opt;
          r.pc     = npc;
          q.push_back(r);
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    rec_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    chk("ready", ready, m_ready());
    chk("R_wen", R_wen, e.r_wen);
    chk("F_wen", F_wen, e.f_wen);
    chk("M_wen", M_wen, e.m_wen);
    chk("retire", retire, e.ret);
    chk("redirect", redirect, e.redir);
    if (e.r_wen) begin
      chk("R_waddr", R_waddr, e.r_addr);
      chk("R_wdata", R_wdata, e.r_data);
    end
    if (e.f_wen) begin
      chk("F_waddr", F_waddr, e.f_addr);
      chk("F_wdata", F_wdata, e.f_data);
    end
    if (e.m_wen) begin
      chk("M_waddr", M_waddr, e.m_addr);
      chk("M_wdata", M_wdata, e.m_data);
    end
    chk("commit_pc", commit_pc, m_commit);
    chk("instret", instret, m_instret);
    if (retire) ret_cnt++;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction from posedge+1 and hold it until the stage takes it.
  task automatic send(input logic [1:0] g, input logic [4:0] idx, input logic po,
                      input logic [31:0] n, input logic [31:0] r, input logic [31:0] f,
                      input logic [511:0] m);
    ME_valid = 1'b1;
    rd_group = g;
    rd_index = idx;
    pc_opt   = po;
    npc      = n;
    res_R    = r;
    res_F    = f;
    res_M    = m;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (m_ready()) break;
      if (i > 8) begin
        chk("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    ME_valid = 1'b0;
  endtask

  logic [511:0] mat;
  logic [511:0] mat2;

  initial begin
    rst = 1'b0; ME_valid = 1'b0; rd_group = 2'd0; rd_index = 5'd0; pc_opt = 1'b0;
    npc = 32'd0; res_R = 32'd0; res_F = 32'd0; res_M = '0;
    for (int k = 0; k < 16; k++) mat[k*32 +: 32] = 32'(k);
    for (int k = 0; k < 16; k++) mat2[k*32 +: 32] = 32'hA000_0000 + 32'(k);

    // Held in reset.
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_R_wdata", R_wdata, 32'd0);
    chk("rst_M_wdata", M_wdata, 128'd0);
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready, 1'b1);

    // Integer write, then a suppressed x0 write that still retires.
    sync();
    send(2'b01, 5'd7, 1'b0, 32'h104, 32'hDEAD_BEEF, 32'd0, '0);
    @(negedge clk);
    chk("r_wen", R_wen, 1'b1);
    chk("r_waddr", R_waddr, 5'd7);
    chk("r_wdata", R_wdata, 32'hDEAD_BEEF);
    chk("r_retire", retire, 1'b1);
    @(negedge clk);
    chk("r_commit_pc", commit_pc, 32'h104);
    chk("r_instret", instret, 64'd1);
    sync();
    send(2'b01, 5'd0, 1'b0, 32'h108, 32'h1234_5678, 32'd0, '0);
    @(negedge clk);
    chk("x0_wen", R_wen, 1'b0);
    chk("x0_retire", retire, 1'b1);
    @(negedge clk);
    chk("x0_instret", instret, 64'd2);

    // Matrix write: four beats to rows 12..15.
    sync();
    send(2'b11, 5'd3, 1'b0, 32'h200, 32'd0, 32'd0, mat);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("m_waddr", M_waddr, 7'd12 + 7'(b));
      chk("m_ready", ready, (b == 3));
      chk("m_retire", retire, (b == 3));
      if (b == 0) chk("m_beat0", M_wdata, 128'h00000003_00000002_00000001_00000000);
    end
    @(negedge clk);
    chk("m_instret", instret, 64'd3);

    // Back-to-back F, M, R with ME_valid held high; f0 is writable.
    sync();
    ret_cnt = 0;
    send(2'b10, 5'd0, 1'b0, 32'h300, 32'd0, 32'h3F80_0000, '0);
    send(2'b11, 5'd1, 1'b0, 32'h304, 32'd0, 32'd0, mat2);
    send(2'b01, 5'd2, 1'b0, 32'h308, 32'h55, 32'd0, '0);
    @(negedge clk);
    chk("b2b_r_wen", R_wen, 1'b1);
    @(negedge clk);
    chk("b2b_retires", ret_cnt, 3);
    chk("b2b_instret", instret, 64'd6);

    // Redirect without a write.
    sync();
    send(2'b00, 5'd9, 1'b1, 32'h2000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
    @(negedge clk);
    chk("redir_retire", retire, 1'b1);
    chk("redir_pulse", redirect, 1'b1);
    chk("redir_wens", {R_wen, F_wen, M_wen}, 3'b000);
    @(negedge clk);
    chk("redir_commit_pc", commit_pc, 32'h2000);
    chk("redir_gone", redirect, 1'b0);

    // Counter wrap.
    #1;
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    #1;
    chk("wrap_preset", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    sync();
    send(2'b01, 5'd9, 1'b0, 32'h400, 32'h9, 32'd0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_instret", instret, 64'd0);

    // Reset in the middle of a matrix sequence aborts it.
    sync();
    send(2'b11, 5'd5, 1'b1, 32'h500, 32'd0, 32'd0, mat);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_M_wen", M_wen, 1'b0);
    chk("abort_M_waddr", M_waddr, 7'd0);
    chk("abort_M_wdata", M_wdata, 128'd0);
    chk("abort_ready", ready, 1'b0);
    chk("abort_retire", retire, 1'b0);
    chk("abort_commit_pc", commit_pc, 32'd0);
    chk("abort_instret", instret, 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_post_ready", ready, 1'b1);
    repeat (4) @(negedge clk);
    chk("abort_post_instret", instret, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
